// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-store geometry and loader state encoding
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_BYTES  = 1 << IMEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serialises streamed 32-bit words into big-endian byte writes
// of the instruction store; MSB lands at the word address.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       data_q, data_d;
  logic              wrap_q, wrap_d;
  logic [7:0]        byte_sel;

  always_comb begin
    byte_sel = data_q[31:24];
    case (byte_idx_q)
      2'd0: byte_sel = data_q[31:24];
      2'd1: byte_sel = data_q[23:16];
      2'd2: byte_sel = data_q[15:8];
      2'd3: byte_sel = data_q[7:0];
      default: byte_sel = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    data_d       = data_q;
    wrap_d       = wrap_q;

    in_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          ptr_d        = base_addr & ALIGN_MASK;
          words_left_d = word_count;
          wrap_d       = 1'b0;
          state_d      = (word_count == '0) ? DONE : WAIT_WORD;
        end
      end

      WAIT_WORD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          data_d     = in_data;
          byte_idx_d = 2'd0;
          state_d    = WRITE;
        end
      end

      WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        mem_addr   = ptr_q;
        mem_wdata  = byte_sel;
        ptr_d      = ptr_q + 1'b1;
        byte_idx_d = byte_idx_q + 1'b1;
        // Overflow past the top of the store is flagged but not fatal.
        if (ptr_q == LAST_ADDR) begin
          wrap_d = 1'b1;
        end
        if (byte_idx_q == 2'd3) begin
          words_left_d = words_left_q - 1'b1;
          state_d      = (words_left_q == CNT_W'(1)) ? DONE : WAIT_WORD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign wrap_err = wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      data_q       <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      data_q       <= data_d;
      wrap_q       <= wrap_d;
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the byte-addressed, big-endian, read-only instruction memory. Accepts 32-bit instruction words over a valid/ready stream. Serialises each word into four byte writes: MSB at the word address, LSB at address+3. Fills the 1024-byte instruction store before the processor is released from reset, e.g. from a testbench, UART bridge or boot ROM.

Parameters:
ADDR_W, 10, byte address width of instruction store
MEM_BYTES, 1024, store size in bytes (2**ADDR_W)
CNT_W, 9, width of word_count (max 2**(ADDR_W-2) = 256 words)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE
base_addr  in  ADDR_W  first byte address; bits [1:0] forced to 0 (word aligned)
word_count  in  CNT_W  number of words to load; latched on start
in_valid  in  1  in_data holds a word
in_data  in  32  instruction word, bit 31 = first byte written
in_ready  out  1  loader accepts a word this cycle
mem_we  out  1  byte write strobe to instruction store
mem_addr  out  ADDR_W  byte address of the write
mem_wdata  out  8  byte value of the write
busy  out  1  load in progress (WAIT_WORD or WRITE)
done  out  1  high in DONE until the next start
wrap_err  out  1  sticky: the byte pointer wrapped MEM_BYTES-1 -> 0 during this load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ptr=0, words_left=0, byte_idx=0, data reg=0; all outputs 0. Takes effect immediately, so mem_we drops without waiting for a clock edge. Instruction store contents are not touched.
- States: IDLE, WAIT_WORD, WRITE, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE/DONE + start=1:
  - latch ptr = {base_addr[ADDR_W-1:2], 2'b00} and words_left = word_count; clear wrap_err and done.
  - if word_count == 0: next state DONE; no writes.
  - otherwise: next state WAIT_WORD.
- start while busy is ignored.
- WAIT_WORD: in_ready=1.
  - On in_valid && in_ready at edge k: capture in_data, byte_idx=0, go to WRITE.
  - Without in_valid: hold; no writes.
- WRITE: in_ready=0, mem_we=1, mem_addr=ptr, mem_wdata = data[31-8*byte_idx -: 8].
  - Each cycle: ptr = ptr+1 mod MEM_BYTES; byte_idx++.
  - When ptr goes from MEM_BYTES-1 to 0: set wrap_err; writing continues.
  - At byte_idx==3: words_left--; if it reaches 0 go to DONE, otherwise go to WAIT_WORD.
- Timing: an accept at edge k gives mem_we high in cycles k+1..k+4. Each word costs at least 5 cycles.
- DONE: done=1, busy=0, mem_we=0. Stays in DONE until start or reset.
- word_count > 256 is legal: the pointer wraps, earlier bytes are overwritten, and wrap_err=1.
- in_data is sampled only on an accept; changes at any other time have no effect.

Decomposition:
- Shared package imem_pkg:
  - constants IMEM_ADDR_W=10, IMEM_BYTES=1024
  - enum loader_state_t {IDLE, WAIT_WORD, WRITE, DONE}
  - the instruction store and fetch unit also use IMEM_ADDR_W and IMEM_BYTES.
- No sub-module: the byte serialiser is a 2-bit index plus a mux, kept inline.

Test Plan:
- Reset check: hold rst_n=0, then release -> in_ready, mem_we, busy, done, wrap_err all 0; no writes for 10 idle cycles.
- Single word: start, base=0x000, count=1, word 0x20210001 -> writes (0x000,0x20), (0x001,0x21), (0x002,0x00), (0x003,0x01) in 4 consecutive cycles; done=1 on the next cycle; wrap_err=0.
- Back-pressure: count=2, second in_valid delayed 3 cycles -> in_ready held at 1, no mem_we during the gap; second word (0x03FFF020) written at 0x004..0x007 as 0x03, 0xFF, 0xF0, 0x20.
- Alignment and wrap: base=0x3FE, count=2 -> first word written at 0x3FC..0x3FF, second at 0x000..0x003; wrap_err=1 and stays set in DONE.
- Zero count and start-while-busy: count=0 -> done=1 with no writes. Then a new load with count=1, pulsing start again mid-WRITE -> start ignored, exactly 4 writes.
- Reset mid-write: drop rst_n during the third byte -> mem_we=0 before the next edge, state IDLE; a new start then loads correctly from base.
